// File: rtl/apb_gpio_v2_if.sv
// APB slave bus bundle for the GPIO block: address/control/write data in, read data and status out.
// Pure wiring; timing and backpressure are defined by the slave, which completes with zero wait states.
interface apb_gpio_v2_if;
  logic [31:0] Paddr;
  logic        Pwrite;
  logic        Psel;
  logic        Penable;
  logic [31:0] Pwdata;
  logic [31:0] Prdata;
  logic        Pready;
  logic        Pslverr;

  modport master (
    output Paddr, Pwrite, Psel, Penable, Pwdata,
    input  Prdata, Pready, Pslverr
  );

  modport slave (
    input  Paddr, Pwrite, Psel, Penable, Pwdata,
    output Prdata, Pready, Pslverr
  );
endinterface

// File: rtl/apb_gpio_v2.sv
// APB GPIO: LED/SEG registers plus synchronized switch channels that raise change interrupts.
// Zero wait states (Pready tied high, no backpressure); Prdata combinational, writes land on the access edge.
module apb_gpio_v2 #(
  parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
  parameter int          SW_CH     = 2,
  parameter logic [31:0] LED_RST   = 32'hff00ff00
) (
  input  logic                Pclk,
  input  logic                Prst_n,
  apb_gpio_v2_if.slave        apb,
  output logic [31:0]         LED,
  output logic [31:0]         SEG,
  input  logic [32*SW_CH-1:0] SW,
  output logic                irq
);
  localparam logic [7:0] OFF_LED  = 8'h00;
  localparam logic [7:0] OFF_SET  = 8'h04;
  localparam logic [7:0] OFF_CLR  = 8'h08;
  localparam logic [7:0] OFF_SEG  = 8'h0C;
  localparam logic [7:0] OFF_EN   = 8'h10;
  localparam logic [7:0] OFF_STAT = 8'h14;
  localparam logic [7:0] OFF_SW0  = 8'h18;

  logic [31:0]         off;
  logic [7:0]          reg_off;
  logic                in_win;
  logic                hit_sw;
  logic                acc_ok;
  logic                wr_en;
  logic [31:0]         sw_rd;
  logic [31:0]         rd_dat;
  logic [SW_CH-1:0]    irq_en;
  logic [SW_CH-1:0]    irq_stat;
  logic [SW_CH-1:0]    sw_chg;
  logic [SW_CH-1:0]    w1c;
  logic [32*SW_CH-1:0] sw_meta;
  logic [32*SW_CH-1:0] sw_sync;
  logic [32*SW_CH-1:0] sw_prev;

  // Subtracting the base keeps the window check correct even for a base not aligned to 256 bytes.
  assign off     = apb.Paddr - BASE_ADDR;
  assign reg_off = off[7:0];
  assign in_win  = (off[31:8] == 24'd0);

  always_comb begin
    hit_sw = 1'b0;
    sw_rd  = '0;
    for (int i = 0; i < SW_CH; i++) begin
      if (reg_off == 8'(OFF_SW0 + 8'(4 * i))) begin
        hit_sw = 1'b1;
        sw_rd  = sw_sync[32*i +: 32];
      end
    end
  end

  // Switch channels are read-only, so a write there is an error rather than a silent drop.
  assign acc_ok = in_win && (apb.Paddr[1:0] == 2'b00) &&
                  ((reg_off <= OFF_STAT) || (hit_sw && !apb.Pwrite));
  assign wr_en  = apb.Psel && apb.Penable && apb.Pwrite && acc_ok;
  assign w1c    = (wr_en && (reg_off == OFF_STAT)) ? apb.Pwdata[SW_CH-1:0] : '0;

  always_comb begin
    sw_chg = '0;
    for (int i = 0; i < SW_CH; i++) begin
      sw_chg[i] = |(sw_sync[32*i +: 32] ^ sw_prev[32*i +: 32]);
    end
  end

  always_comb begin
    rd_dat = '0;
    case (reg_off)
      OFF_LED:          rd_dat = LED;
      OFF_SET, OFF_CLR: rd_dat = '0;
      OFF_SEG:          rd_dat = SEG;
      OFF_EN:           rd_dat = 32'(irq_en);
      OFF_STAT:         rd_dat = 32'(irq_stat);
      default:          rd_dat = sw_rd;
    endcase
  end

  always_ff @(posedge Pclk or negedge Prst_n) begin
    if (!Prst_n) begin
      LED      <= LED_RST;
      SEG      <= '0;
      irq_en   <= '0;
      irq_stat <= '0;
      sw_meta  <= '0;
      sw_sync  <= '0;
      sw_prev  <= '0;
    end else begin
      sw_meta  <= SW;
      sw_sync  <= sw_meta;
      sw_prev  <= sw_sync;
      // A change event in the same cycle as a clear keeps the bit set.
      irq_stat <= (irq_stat & ~w1c) | sw_chg;
      if (wr_en) begin
        case (reg_off)
          OFF_LED: LED    <= apb.Pwdata;
          OFF_SET: LED    <= LED | apb.Pwdata;
          OFF_CLR: LED    <= LED & ~apb.Pwdata;
          OFF_SEG: SEG    <= apb.Pwdata;
          OFF_EN:  irq_en <= apb.Pwdata[SW_CH-1:0];
          default: ;
        endcase
      end
    end
  end

  assign apb.Pready  = 1'b1;
  assign apb.Prdata  = (apb.Psel && !apb.Pwrite && acc_ok) ? rd_dat : '0;
  assign apb.Pslverr = Prst_n && apb.Psel && apb.Penable && !acc_ok;
  assign irq         = |(irq_stat & irq_en);
endmodule

// File: tb/tb_apb_gpio_v2.sv
// Randomized APB/switch stimulus for apb_gpio_v2 checked against a cycle-level behavioural model.
// The model treats each switch channel as its input delayed two edges, flagging a change one edge later.
module tb_apb_gpio_v2;
  localparam int          SW_CH   = 2;
  localparam logic [31:0] BASE    = 32'h2000_0000;
  localparam logic [31:0] LED_RST = 32'hff00ff00;
  localparam logic [31:0] OFFS [13] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18,
                                        32'h1C, 32'h20, 32'h02, 32'h40, 32'h100, 32'hFFFF_FFFC};

  logic                Pclk = 1'b0;
  logic                Prst_n = 1'b0;
  logic [31:0]         LED, SEG;
  logic [32*SW_CH-1:0] SW = '0;
  logic                irq;
  int                  n_tests = 0;
  int                  n_fail = 0;

  apb_gpio_v2_if apb ();

  apb_gpio_v2 #(.BASE_ADDR(BASE), .SW_CH(SW_CH), .LED_RST(LED_RST)) dut (
    .Pclk(Pclk), .Prst_n(Prst_n), .apb(apb), .LED(LED), .SEG(SEG), .SW(SW), .irq(irq)
  );

  always #5 Pclk = ~Pclk;

  // ---------------- reference model ----------------
  logic [31:0]         m_led, m_seg;
  logic [SW_CH-1:0]    m_en, m_stat, m_set, m_w1c;
  logic [32*SW_CH-1:0] m_hist[$];   // switch input sampled at the last three edges, oldest first
  int                  m_idx;

  // Returns 1 for a legal access; slot is the word index within the window.
  function automatic bit m_decode(input logic [31:0] addr, input bit is_wr, output int slot);
    logic [31:0] o;
    o = addr - BASE;
    slot = int'(o >> 2);
    if (o >= 32'h100 || addr[1:0] != 2'b00) return 1'b0;
    if (o <= 32'h14) return 1'b1;
    if (o >= 32'h18 && o < 32'h18 + 32'(4 * SW_CH)) return !is_wr;
    return 1'b0;
  endfunction

  function automatic logic m_err(input logic [31:0] addr, input bit is_wr);
    int slot;
    return !m_decode(addr, is_wr, slot);
  endfunction

  function automatic logic [31:0] m_rdata(input logic [31:0] addr);
    int slot;
    if (!m_decode(addr, 1'b0, slot)) return 32'h0;
    case (slot)
      0:       return m_led;
      1, 2:    return 32'h0;
      3:       return m_seg;
      4:       return 32'(m_en);
      5:       return 32'(m_stat);
      default: return m_hist[1][32*(slot-6) +: 32];
    endcase
  endfunction

  always @(posedge Pclk or negedge Prst_n) begin
    if (!Prst_n) begin
      m_led = LED_RST;
      m_seg = '0;
      m_en  = '0;
      m_stat = '0;
      m_hist = {};
      repeat (3) m_hist.push_back('0);
    end else begin
      for (int i = 0; i < SW_CH; i++)
        m_set[i] = (m_hist[1][32*i +: 32] != m_hist[0][32*i +: 32]);
      m_w1c = '0;
      if (apb.Psel && apb.Penable && apb.Pwrite && m_decode(apb.Paddr, 1'b1, m_idx)) begin
        case (m_idx)
          0:       m_led = apb.Pwdata;
          1:       m_led = m_led | apb.Pwdata;
          2:       m_led = m_led & ~apb.Pwdata;
          3:       m_seg = apb.Pwdata;
          4:       m_en  = apb.Pwdata[SW_CH-1:0];
          5:       m_w1c = apb.Pwdata[SW_CH-1:0];
          default: ;
        endcase
      end
      m_stat = (m_stat & ~m_w1c) | m_set;
      m_hist.push_back(SW);
      void'(m_hist.pop_front());
    end
  end

  // ---------------- checking and bus tasks ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_idle();
    apb.Psel = 1'b0; apb.Penable = 1'b0; apb.Pwrite = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge Pclk);
      #1;
      check("irq", 32'(irq), 32'(|(m_stat & m_en)));
      check("led_port", LED, m_led);
      check("seg_port", SEG, m_seg);
      check("idle_prdata", apb.Prdata, 32'h0);
    end
  endtask

  task automatic rd(input logic [31:0] off, output logic [31:0] dat, output logic err);
    logic [31:0] a;
    a = BASE + off;
    @(negedge Pclk);
    apb.Paddr = a; apb.Pwrite = 1'b0; apb.Psel = 1'b1; apb.Penable = 1'b0;
    #1;
    check("rd_setup_prdata", apb.Prdata, m_rdata(a));
    check("rd_setup_slverr", 32'(apb.Pslverr), 32'h0);
    @(negedge Pclk);
    apb.Penable = 1'b1;
    #1;
    dat = apb.Prdata;
    err = apb.Pslverr;
    check("rd_prdata", dat, m_rdata(a));
    check("rd_slverr", 32'(err), 32'(m_err(a, 1'b0)));
    check("rd_pready", 32'(apb.Pready), 32'h1);
    @(posedge Pclk);
    #1 bus_idle();
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] dat, output logic err);
    logic [31:0] a;
    a = BASE + off;
    @(negedge Pclk);
    apb.Paddr = a; apb.Pwdata = dat; apb.Pwrite = 1'b1; apb.Psel = 1'b1; apb.Penable = 1'b0;
    #1;
    check("wr_setup_prdata", apb.Prdata, 32'h0);
    @(negedge Pclk);
    apb.Penable = 1'b1;
    #1;
    err = apb.Pslverr;
    check("wr_slverr", 32'(err), 32'(m_err(a, 1'b1)));
    @(posedge Pclk);
    #1 bus_idle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] d;
    logic        e;
    int          ch;
    bus_idle();
    apb.Paddr = '0;
    apb.Pwdata = '0;

    repeat (3) @(negedge Pclk);
    #1;
    check("rst_led", LED, LED_RST);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_slverr", 32'(apb.Pslverr), 32'h0);
    @(negedge Pclk);
    Prst_n = 1'b1;

    rd(32'h00, d, e);  check("led_reset_read", d, 32'hff00ff00);  check("led_reset_err", 32'(e), 32'h0);
    rd(32'h0C, d, e);  check("seg_reset_read", d, 32'h0);

    wr(32'h00, 32'h0000_00F0, e);
    wr(32'h04, 32'h0000_000F, e);
    wr(32'h08, 32'h0000_0030, e);
    rd(32'h00, d, e);  check("led_set_clr", d, 32'h0000_00CF);
    rd(32'h04, d, e);  check("led_set_read0", d, 32'h0);      check("led_set_rd_err", 32'(e), 32'h0);

    @(negedge Pclk);
    SW[63:32] = 32'h1234;
    rd(32'h1C, d, e);  check("sw1_after_2_edges", d, 32'h1234);
    rd(32'h14, d, e);  check("stat_after_3_edges", d, 32'h2);
    check("irq_masked", 32'(irq), 32'h0);
    wr(32'h10, 32'h2, e);
    check("irq_enabled", 32'(irq), 32'h1);
    wr(32'h14, 32'h2, e);
    check("irq_cleared", 32'(irq), 32'h0);

    @(negedge Pclk);
    SW[0] = ~SW[0];
    cyc(4);
    @(negedge Pclk);
    SW[0] = ~SW[0];
    wr(32'h14, 32'h1, e);  // clear lands on the same edge as the change event
    rd(32'h14, d, e);  check("set_beats_w1c", 32'(d[0]), 32'h1);

    wr(32'h18, 32'hDEAD_BEEF, e);  check("wr_sw_err", 32'(e), 32'h1);
    rd(32'h40, d, e);  check("unmapped_err", 32'(e), 32'h1);  check("unmapped_data", d, 32'h0);
    rd(32'h02, d, e);  check("unaligned_err", 32'(e), 32'h1); check("unaligned_data", d, 32'h0);
    wr(32'h02, 32'h0, e);  check("unaligned_wr_err", 32'(e), 32'h1);
    rd(32'h00, d, e);  check("led_untouched", d, 32'h0000_00CF);

    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 9))
        0, 1: begin
          @(negedge Pclk);
          ch = int'($urandom_range(0, SW_CH - 1));
          if ($urandom_range(0, 3) == 0) SW[32*ch +: 32] = $urandom;
          else SW[32*ch + int'($urandom_range(0, 31))] ^= 1'b1;
        end
        2, 3, 4: wr(OFFS[$urandom_range(0, 12)], $urandom, e);
        5, 6, 7, 8: rd(OFFS[$urandom_range(0, 12)], d, e);
        default: cyc(int'($urandom_range(1, 4)));
      endcase
    end
    cyc(5);

    @(negedge Pclk);
    SW = {32'h0000_0005, 32'h0};
    cyc(5);
    @(negedge Pclk);
    apb.Paddr = BASE; apb.Pwdata = 32'h0; apb.Pwrite = 1'b1; apb.Psel = 1'b1; apb.Penable = 1'b0;
    @(negedge Pclk);
    apb.Penable = 1'b1;
    #2 Prst_n = 1'b0;
    #1;
    check("midrst_led", LED, LED_RST);
    check("midrst_irq", 32'(irq), 32'h0);
    check("midrst_slverr", 32'(apb.Pslverr), 32'h0);
    bus_idle();
    repeat (2) @(negedge Pclk);
    Prst_n = 1'b1;
    rd(32'h14, d, e);  check("post_rst_stat_2_edges", d, 32'h0);
    rd(32'h14, d, e);  check("post_rst_stat_3_edges", d, 32'h2);
    rd(32'h00, d, e);  check("post_rst_led", d, 32'hff00ff00);
    wr(32'h14, 32'h2, e);
    rd(32'h14, d, e);  check("post_rst_stat_clr", d, 32'h0);
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/apb_gpio_v2.md
APB_GPIO_V2 -- requirements
Module: apb_gpio_v2

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h2000_0000, giving the APB window base; the window is BASE_ADDR..BASE_ADDR+0xFF.
REQ-002 The block SHALL have parameter SW_CH, default 2, legal range 1..8, giving the number of 32-bit switch input channels.
REQ-003 The block SHALL have parameter LED_RST, default 32'hff00ff00, giving the LED reset value.
REQ-004 Pclk  in  1  is the single clock; all flops are rising-edge.
REQ-005 Prst_n  in  1  is the reset, asynchronous and active-low.
REQ-006 Paddr  in  32  APB address; Pwrite in 1 APB direction; Psel in 1 APB select; Penable in 1 APB access phase.
REQ-007 Pwdata  in  32  write data; Prdata out 32 read data; Pready out 1; Pslverr out 1.
REQ-008 LED  out  32  LED register; SEG  out  32  segment register.
REQ-009 SW  in  32*SW_CH  switch inputs, asynchronous; channel i occupies bits [32i+31:32i].
REQ-010 irq  out  1  level interrupt, equal to |(IRQ_STAT & IRQ_EN).

Function
REQ-011 Register map (offset from BASE_ADDR):
- 0x00 LED: RW.
- 0x04 LED_SET: WO; writing 1 to a bit sets that LED bit.
- 0x08 LED_CLR: WO; writing 1 to a bit clears that LED bit.
- 0x0C SEG: RW.
- 0x10 IRQ_EN[SW_CH-1:0]: RW.
- 0x14 IRQ_STAT[SW_CH-1:0]: RW1C.
- 0x18+4*i SW[i]: RO, for i < SW_CH.
REQ-012 Pready SHALL be constant 1; every transfer completes in a single access cycle (zero wait states).
REQ-013 A write SHALL take effect at the rising edge ending the access phase (Psel=1, Penable=1, Pwrite=1), and only then; the setup phase SHALL have no effect.
REQ-014 Prdata SHALL be combinational from register state whenever Psel=1 and Pwrite=0, and SHALL be 0 otherwise.
REQ-015 Reads of LED_SET and LED_CLR SHALL return 0 without error; unused upper bits of IRQ_EN and IRQ_STAT SHALL read 0.
REQ-016 Pslverr SHALL be 1 during the access phase for any of the following: an address outside the map, a non-word-aligned address, or a write to SW[i]. Such an access SHALL change no state and read 0.
REQ-017 Each SW channel SHALL pass through a 2-flop synchronizer; a stable input change SHALL be readable in SW[i] after the 2nd rising edge.
REQ-018 A prev-value register per channel SHALL load from the synchronizer output every cycle.
REQ-019 IRQ_STAT[i] SHALL set on the edge at which the synchronized value differs from prev in any bit, i.e. the 3rd edge after an input change.
REQ-020 If an IRQ_STAT[i] set event and a W1C of that bit occur in the same cycle, the set SHALL win.
REQ-021 irq SHALL be combinational from IRQ_STAT and IRQ_EN, with no added latency.
REQ-022 IRQ_STAT SHALL set regardless of IRQ_EN.

Reset
REQ-023 When Prst_n=0, the block SHALL asynchronously reset LED to LED_RST and SEG, IRQ_EN, IRQ_STAT, synchronizer and prev registers to 0; irq SHALL read 0 and Pslverr SHALL be 0.
REQ-024 Reset asserted mid-transfer SHALL abort the transfer with no write retained; after release the block SHALL accept the next transfer normally.
REQ-025 After reset release, nonzero SW inputs SHALL set IRQ_STAT on the 3rd edge as a change from 0; software clears it.

Verification
REQ-026 Reset with LED_RST default, then read 0x00 and 0x0C -> Prdata 32'hff00ff00 and 0; Pslverr 0.
REQ-027 Write 0x00=0x0000_00F0, then LED_SET=0x0F, then LED_CLR=0x30 -> LED reads 0x0000_00CF; LED_SET reads 0.
REQ-028 With SW_CH=2, set SW channel 1 to 0x1234 -> SW[1] (0x1C) reads 0x1234 after 2 edges; IRQ_STAT=2'b10 after 3 edges; irq=0 until IRQ_EN=2'b10 is written, then irq=1; writing IRQ_STAT=2'b10 clears irq.
REQ-029 Toggle an SW bit so that the set event lands on the same edge as a W1C of that bit -> IRQ_STAT bit remains 1.
REQ-030 Write to 0x18, access 0x40, access 0x02 -> Pslverr=1 in each access phase, Prdata=0, and no register changes.
REQ-031 Assert Prst_n=0 during the access phase of an LED write of 0x0 -> LED=32'hff00ff00 after reset, with no write retained.
